// File: rtl/aes_round_ctrl.sv
// Control sequencer for an iterative AES-128 datapath: walks SubBytes/ShiftRows/
// MixColumns/AddRoundKey through the round schedule with per-step handshake and timeout.
module aes_round_ctrl #(
   parameter int NR      = 10,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       sub_done,
   input  logic       shift_done,
   input  logic       mix_done,
   input  logic       ark_done,
   output logic       load,
   output logic       step_rst,
   output logic       sub_en,
   output logic       shift_en,
   output logic       mix_en,
   output logic       ark_en,
   output logic       state_we,
   output logic [1:0] src_sel,
   output logic [3:0] round,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CLR, S_ISSUE, S_WAIT, S_DONE, S_ERR
   } state_t;

   localparam logic [1:0] SRC_SUB   = 2'd0;
   localparam logic [1:0] SRC_SHIFT = 2'd1;
   localparam logic [1:0] SRC_MIX   = 2'd2;
   localparam logic [1:0] SRC_ARK   = 2'd3;
   localparam logic [3:0] NR_L      = 4'(NR);
   localparam logic [7:0] TO_L      = 8'(TIMEOUT);

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic [1:0] src_q, src_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       load_q, step_rst_q, busy_q, done_q;
   logic [3:0] en_q;
   logic [3:0] done_vec;
   logic       step_done;
   logic [7:0] cnt_inc;

   assign done_vec  = {ark_done, mix_done, shift_done, sub_done};
   assign step_done = done_vec[src_q];
   assign cnt_inc   = cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      src_d   = src_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_d = S_LOAD;
                  round_d = 4'd0;
                  src_d   = SRC_ARK;
                  err_d   = 1'b0;
               end else if (state_q == S_DONE) begin
                  state_d = S_IDLE;
               end
            end
            S_LOAD:  state_d = S_CLR;
            S_CLR:   state_d = S_ISSUE;
            S_ISSUE: begin
               state_d = S_WAIT;
               cnt_d   = 8'd0;
            end
            S_WAIT: begin
               // A done arriving on the final allowed cycle takes precedence over timeout.
               if (step_done) begin
                  if (round_q == NR_L && src_q == SRC_ARK) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_CLR;
                     unique case (src_q)
                        SRC_SUB:   src_d = SRC_SHIFT;
                        SRC_SHIFT: src_d = (round_q == NR_L) ? SRC_ARK : SRC_MIX;
                        SRC_MIX:   src_d = SRC_ARK;
                        default: begin
                           src_d   = SRC_SUB;
                           round_d = round_q + 4'd1;
                        end
                     endcase
                  end
               end else if (cnt_inc == TO_L) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they are glitch-free Moore decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         round_q    <= 4'd0;
         src_q      <= 2'd0;
         cnt_q      <= 8'd0;
         err_q      <= 1'b0;
         load_q     <= 1'b0;
         step_rst_q <= 1'b0;
         en_q       <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         src_q      <= src_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         load_q     <= (state_d == S_LOAD);
         step_rst_q <= (state_d == S_CLR);
         en_q       <= (state_d == S_ISSUE) ? (4'b0001 << src_d) : 4'd0;
         busy_q     <= (state_d == S_LOAD) || (state_d == S_CLR) ||
                       (state_d == S_ISSUE) || (state_d == S_WAIT);
         done_q     <= (state_d == S_DONE);
      end
   end

   assign load     = load_q;
   assign step_rst = step_rst_q;
   assign sub_en   = en_q[0];
   assign shift_en = en_q[1];
   assign mix_en   = en_q[2];
   assign ark_en   = en_q[3];
   assign state_we = (state_q == S_WAIT) && step_done;
   assign src_sel  = src_q;
   assign round    = round_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with an enable-to-done step responder.
module tb_aes_round_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic       sub_done, shift_done, mix_done, ark_done;
   logic       load, step_rst, sub_en, shift_en, mix_en, ark_en, state_we;
   logic [1:0] src_sel;
   logic [3:0] round;
   logic       busy, done, error;

   aes_round_ctrl #(.NR(10), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .sub_done(sub_done), .shift_done(shift_done), .mix_done(mix_done), .ark_done(ark_done),
      .load(load), .step_rst(step_rst), .sub_en(sub_en), .shift_en(shift_en),
      .mix_en(mix_en), .ark_en(ark_en), .state_we(state_we), .src_sel(src_sel),
      .round(round), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Step responder: done rises one edge after enable plus an optional extra delay.
   logic       stale = 1'b0;
   int         dly_step = 0, dly_round = -1, dly_val = 0;
   logic [3:0] rf = '0, rpend = '0;
   int         rcnt [4];
   logic [3:0] en_v;
   assign en_v = {ark_en, mix_en, shift_en, sub_en};

   always @(posedge clk) begin
      for (int s = 0; s < 4; s++) begin
         if (step_rst) begin
            rf[s]    <= 1'b0;
            rpend[s] <= 1'b0;
         end else if (en_v[s]) begin
            if (s == dly_step && int'(round) == dly_round && dly_val > 0) begin
               rpend[s] <= 1'b1;
               rcnt[s]  <= dly_val;
            end else begin
               rf[s] <= 1'b1;
            end
         end else if (rpend[s]) begin
            if (rcnt[s] == 1) begin
               rf[s]    <= 1'b1;
               rpend[s] <= 1'b0;
            end
            rcnt[s] <= rcnt[s] - 1;
         end
      end
   end

   assign sub_done   = stale | rf[0];
   assign shift_done = stale | rf[1];
   assign mix_done   = stale | rf[2];
   assign ark_done   = stale | rf[3];

   int total = 0, bad = 0;
   int cyc, done_cyc, err_cyc, n_done;
   int n_sub, n_shift, n_mix, n_ark, n_we, n_rst, mix_bad, round_bad, max_round, prev_round;
   logic load_c1, err_c1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sample();
      if (cyc == 1) begin
         load_c1 = load;
         err_c1  = error;
      end
      if (sub_en)   n_sub++;
      if (shift_en) n_shift++;
      if (mix_en)   n_mix++;
      if (ark_en)   n_ark++;
      if (state_we) n_we++;
      if (step_rst) n_rst++;
      if (mix_en && round == 4'd10) mix_bad++;
      if (int'(round) != prev_round) begin
         if (int'(round) != prev_round + 1) round_bad++;
         prev_round = int'(round);
      end
      if (int'(round) > max_round) max_round = int'(round);
      if (done) begin
         n_done++;
         if (done_cyc == 0) done_cyc = cyc;
      end
      if (error && err_cyc == 0) err_cyc = cyc;
   endtask

   task automatic step_cycle();
      @(posedge clk);
      #1;
      cyc++;
      sample();
   endtask

   task automatic begin_run();
      done_cyc = 0; err_cyc = 0; n_done = 0;
      n_sub = 0; n_shift = 0; n_mix = 0; n_ark = 0; n_we = 0; n_rst = 0;
      mix_bad = 0; round_bad = 0; max_round = 0; prev_round = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      sample();
   endtask

   task automatic go(input int limit);
      begin_run();
      while (cyc < limit && done_cyc == 0 && err_cyc == 0) step_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {load, step_rst, en_v, state_we, src_sel, round, busy, done, error}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Nominal run
      go(300);
      chk("nom_load_c1", load_c1, 1);
      chk("nom_done_cyc", done_cyc, 122);
      chk("nom_busy_at_done", busy, 0);
      chk("nom_sub", n_sub, 10);
      chk("nom_shift", n_shift, 10);
      chk("nom_mix", n_mix, 9);
      chk("nom_ark", n_ark, 11);
      chk("nom_we", n_we, 40);
      chk("nom_step_rst", n_rst, 40);
      chk("nom_round_seq", round_bad, 0);
      chk("nom_max_round", max_round, 10);
      chk("nom_mix_r10", mix_bad, 0);
      // Back-to-back: start held in DONE goes straight to LOAD
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_load", load, 1);
      chk("b2b_round", round, 0);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;

      // Mix of round 3 returns five cycles late
      dly_step = 2; dly_round = 3; dly_val = 5;
      go(300);
      chk("dly_done_cyc", done_cyc, 127);
      chk("dly_err", err_cyc, 0);
      dly_round = -1;

      // Withheld ark in round 2 times out
      dly_step = 3; dly_round = 2; dly_val = 100000;
      go(300);
      chk("to_err_cyc", err_cyc, 43);
      chk("to_busy", busy, 0);
      chk("to_no_done", done_cyc, 0);
      repeat (3) step_cycle();
      chk("to_err_hold", error, 1);
      dly_round = -1;
      go(300);
      chk("to_err_cleared", err_c1, 0);
      chk("to_rerun_done", done_cyc, 122);
      chk("to_rerun_err", err_cyc, 0);

      // Done on exactly the last allowed WAIT cycle
      dly_step = 3; dly_round = 2; dly_val = 14;
      go(300);
      chk("edge_done_cyc", done_cyc, 136);
      chk("edge_no_err", err_cyc, 0);
      dly_round = -1;

      // Ignored start while busy, then abort in round 5
      begin_run();
      while (round != 4'd5 && cyc < 200) begin
         step_cycle();
         if (cyc == 10) start = 1'b1;
         if (cyc == 11) start = 1'b0;
      end
      chk("abort_r5_cyc", cyc, 53);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_outs", {load, step_rst, en_v, state_we, busy, done}, 0);
      chk("abort_err", error, 0);
      @(negedge clk);
      abort = 1'b0;
      n_done = 0;
      repeat (5) step_cycle();
      chk("abort_no_done", n_done, 0);
      chk("abort_idle", busy, 0);

      // Reset in round 4, then a fresh run
      begin_run();
      while (round != 4'd4 && cyc < 200) step_cycle();
      chk("rst_r4_cyc", cyc, 41);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_outs", {load, step_rst, en_v, state_we, src_sel, round, busy, done, error}, 0);
      @(negedge clk);
      rst = 1'b0;
      go(300);
      chk("rst_rerun_done", done_cyc, 122);

      // All done inputs stuck high
      stale = 1'b1;
      go(300);
      chk("stale_done_cyc", done_cyc, 122);
      chk("stale_we", n_we, 40);
      chk("stale_sub", n_sub, 10);
      chk("stale_mix", n_mix, 9);
      chk("stale_ark", n_ark, 11);
      stale = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
